fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle decode/execute core.
- Generates sequential word addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers {pc, instr} pairs in a small prefetch FIFO.
- Presents those pairs to the core over a valid/ready output channel; a branch/jump redirect flushes everything and restarts fetch.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage carries no reset; only the pointers and count are control state.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests, in-order responses,
// prefetch FIFO to the core, and single-cycle redirect that flushes and restarts fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  target_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W:0]   occupancy;
    logic             req_fire;
    logic             rsp_take;
    logic             push;
    logic             pop;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Buffered entries plus outstanding requests may never exceed DEPTH, so a push never overflows.
    assign occupancy      = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take   = imem_rsp_valid && (inflight != '0);
    assign push       = rsp_take && !redirect_valid && (drop_cnt == '0);
    assign push_entry = '{pc: resp_pc, instr: imem_rsp_data};
    assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : '0;

    // Every request still outstanding at a redirect belongs to the old stream, so the
    // drop count becomes the full in-flight total minus any response retiring right now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                drop_cnt <= inflight - CNT_W'(rsp_take);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                if (push)
                    resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
                if (rsp_take && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (inflight == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency and a queue-based reference.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { bit ordy; bit exp_rv; logic [31:0] exp_addr; bit exp_ov; logic [31:0] exp_pc; } vec_t;

    req_t        mem_q[$];   // requests accepted by memory, oldest first
    ent_t        fifo_q[$];  // instructions the core should still see, in order
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          checks;
    int          failures;
    logic        s_rv, s_ov;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the reference, then advance it.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit ordy, input bit qrdy, input int k);
        bit   rsp;
        bit   exp_rv;
        bit   exp_ov;
        req_t r;
        r = '{32'h0, 0, 1'b0};
        @(negedge clk);
        cyc++;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        if (rsp) r = mem_q.pop_front();
        redirect_valid = rd;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(r.addr) : 32'h0;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_ov = out_valid; s_pc = out_pc;
        exp_rv = !rd && ((fifo_q.size() + mem_q.size() + int'(rsp)) < DEPTH);
        exp_ov = fifo_q.size() > 0;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc", out_pc, fifo_q[0].pc);
            check("out_instr", out_instr, fifo_q[0].instr);
        end
        if (rd) begin
            fifo_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_fetch_pc = rpc & ~32'h3;
        end else begin
            if (exp_ov && ordy) void'(fifo_q.pop_front());
            if (rsp && !r.stale) fifo_q.push_back('{r.addr, instr_of(r.addr)});
            if (exp_rv && qrdy) begin
                mem_q.push_back('{m_fetch_pc, cyc + k, 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    endtask

    // Reset asserted between clock edges; outputs must drop without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_out_pc"}, out_pc, 32'h0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        mem_q.delete();
        fifo_q.delete();
        m_fetch_pc = RESET_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs = '{
            '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0},
            '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4},
            '{1'b0, 1'b1, 32'h10, 1'b1, 32'h8},
            '{1'b0, 1'b1, 32'h14, 1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h00, 1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h00, 1'b1, 32'h8}
        };
        checks = 0; failures = 0; cyc = 0;
        m_fetch_pc = RESET_PC;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset release, 1-cycle memory, then back-pressure until the credit limit is hit.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, vecs[i].ordy, 1'b1, 1);
            check($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) check($sformatf("vec%0d_req_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) check($sformatf("vec%0d_out_pc", i), s_pc, vecs[i].exp_pc);
        end
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // Fresh reset, core stalled 10 cycles, then drain 0x0..0xC in order.
        async_reset("stall");
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("stall_full_pc", s_pc, 32'h0);
        check("stall_req_blocked", 32'(s_rv), 32'h0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // Redirect with slow memory so several stale responses are still owed.
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
        step(1'b1, 32'h100, 1'b1, 1'b1, 3);
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 3);

        // Redirect to an unaligned target coinciding with a response and a pop.
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        step(1'b1, 32'h203, 1'b1, 1'b1, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1);
        check("unaligned_resume", s_addr, 32'h200);
        check("flushed_empty", 32'(s_ov), 32'h0);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // Address wrap through the top of the address space.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        // Back-to-back redirects with responses still pending.
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 4);
        step(1'b1, 32'h400, 1'b1, 1'b1, 4);
        step(1'b1, 32'h500, 1'b1, 1'b1, 4);
        step(1'b0, 32'h0, 1'b1, 1'b1, 4);
        step(1'b1, 32'h600, 1'b1, 1'b1, 4);
        repeat (15) step(1'b0, 32'h0, 1'b1, 1'b1, 4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 20) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 1 + int'($urandom % 4));
        end

        // Fill the FIFO, then reset mid-cycle.
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("prereset_full", 32'(s_ov), 32'h1);
        async_reset("midrst");
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
